// File: rtl/pipe_hazard_unit.sv
// -----------------------------------------------------------------------------
// pipe_hazard_unit
//
// Hazard / forwarding controller for the in-order pipeline. Keeps a shifting
// history of the destination registers of the FWD_DEPTH instructions that are
// past decode (entry 0 = EX, entry 1 = MEM, ...). From that history it drives:
//   - operand forwarding selects for the decode instruction's two sources,
//   - load-use stall with bubble insertion into ID/EX,
//   - condition-flag forwarding from the instruction currently in EX,
//   - IF/ID flush when a decode-stage branch resolves taken.
//
// Optional feature macro: PIPE_HAZARD_STATS_EN
//   defined   : stall_count / flush_count are saturating 32-bit event counters
//   undefined : both ports are tied to zero and no counter flops exist
//
// Ports:
//   clk                           rising-edge clock
//   reset                         asynchronous, active-low; clears all state
//   issue_valid                   decode stage holds a real instruction
//   issue_rd / issue_we           destination register and its write enable
//   issue_load                    decode instruction is a load
//   issue_rn / issue_rm           source registers
//   issue_rn_used / issue_rm_used source actually read
//   issue_set_flg / issue_use_flg instruction writes / reads NZCV
//   br_taken                      decode-stage branch resolved taken
//   ext_stall                     global freeze (memory wait)
//   fwd_a / fwd_b                 0 = register file, k = history entry k-1
//   fwd_flag                      take ALU flags combinationally from EX
//   stall_pc / stall_ifid         hold PC / hold IF/ID
//   bubble_idex                   load a NOP into ID/EX
//   flush_ifid                    clear IF/ID on the next edge
//   stall_count / flush_count     event counters (optional feature)
// -----------------------------------------------------------------------------
module pipe_hazard_unit #(
  parameter int REG_AW    = 5,
  parameter int FWD_DEPTH = 2,
  parameter int LOAD_LAT  = 1,
  parameter int ZERO_REG  = 31
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              issue_valid,
  input  logic [REG_AW-1:0] issue_rd,
  input  logic              issue_we,
  input  logic              issue_load,
  input  logic [REG_AW-1:0] issue_rn,
  input  logic [REG_AW-1:0] issue_rm,
  input  logic              issue_rn_used,
  input  logic              issue_rm_used,
  input  logic              issue_set_flg,
  input  logic              issue_use_flg,
  input  logic              br_taken,
  input  logic              ext_stall,
  output logic [2:0]        fwd_a,
  output logic [2:0]        fwd_b,
  output logic              fwd_flag,
  output logic              stall_pc,
  output logic              stall_ifid,
  output logic              bubble_idex,
  output logic              flush_ifid,
  output logic [31:0]       stall_count,
  output logic [31:0]       flush_count
);

  // cnt never exceeds LOAD_LAT < FWD_DEPTH <= 7, so three bits always suffice.
  localparam int CNT_W = 3;
  localparam logic [REG_AW-1:0] ZERO_RD = REG_AW'(ZERO_REG);

  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] rd;
    logic              we;
    logic              set_flg;
    logic [CNT_W-1:0]  cnt;      // cycles until the result is forwardable
  } entry_t;

  entry_t hist [FWD_DEPTH];
  entry_t new_entry;

  logic [2:0] sel_a, sel_b;
  logic       haz_a, haz_b;
  logic       hazard;
  logic       flush_int;

  // A history entry supplies a source when it is a live register write to
  // that register; the zero register never carries a dependency.
  function automatic logic src_hit(entry_t e, logic [REG_AW-1:0] src,
                                   logic used, logic valid);
    return valid && used && e.valid && e.we && (e.rd == src) && (src != ZERO_RD);
  endfunction

  // Moving one stage down the history brings a pending load one cycle closer.
  function automatic entry_t age(entry_t e);
    entry_t r;
    r = e;
    if (r.cnt != '0) r.cnt = r.cnt - CNT_W'(1);
    return r;
  endfunction

  // ---------------------------------------------------------------------------
  // Source matching. Scanning oldest to youngest lets the youngest producer
  // overwrite older ones, so the most recent write of a register wins.
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every always_comb output gets a default first; a path that leaves
    // one unassigned would infer a latch.
    sel_a = '0;
    sel_b = '0;
    haz_a = 1'b0;
    haz_b = 1'b0;
    for (int k = FWD_DEPTH - 1; k >= 0; k--) begin
      if (src_hit(hist[k], issue_rn, issue_rn_used, issue_valid)) begin
        sel_a = 3'(k + 1);
        haz_a = (hist[k].cnt != '0);
      end
      if (src_hit(hist[k], issue_rm, issue_rm_used, issue_valid)) begin
        sel_b = 3'(k + 1);
        haz_b = (hist[k].cnt != '0);
      end
    end
  end

  assign hazard    = haz_a | haz_b;
  assign flush_int = br_taken & issue_valid & ~hazard & ~ext_stall;

  // Entry 0 takes the decode instruction, or a bubble when it cannot issue.
  always_comb begin
    new_entry = '0;
    if (issue_valid && !hazard) begin
      new_entry.valid   = 1'b1;
      new_entry.rd      = issue_rd;
      new_entry.we      = issue_we;
      new_entry.set_flg = issue_set_flg;
      new_entry.cnt     = issue_load ? CNT_W'(LOAD_LAT) : '0;
    end
  end

  // ---------------------------------------------------------------------------
  // History shift register, frozen while the whole pipeline is stalled.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      // NOTE: the history is a handful of control flops, not a RAM, so it is
      // reset in full; a stale valid bit would forward garbage after reset.
      for (int k = 0; k < FWD_DEPTH; k++) hist[k] <= '0;
    end else if (!ext_stall) begin
      // NOTE: non-blocking assignments let every stage read its neighbour's
      // old value, which is exactly the shift; blocking would collapse it.
      hist[0] <= new_entry;
      for (int k = 1; k < FWD_DEPTH; k++) hist[k] <= age(hist[k-1]);
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs. Stall and flush are gated by reset so that asserting reset
  // silences them at once, whatever the decode-side inputs are doing.
  // ---------------------------------------------------------------------------
  assign fwd_a       = sel_a;
  assign fwd_b       = sel_b;
  // Only the instruction in EX has flags not yet in the flag register.
  assign fwd_flag    = issue_use_flg & hist[0].valid & hist[0].set_flg;
  assign stall_pc    = reset & (hazard | ext_stall);
  assign stall_ifid  = reset & (hazard | ext_stall);
  assign bubble_idex = reset & hazard & ~ext_stall;
  assign flush_ifid  = reset & flush_int;

`ifdef PIPE_HAZARD_STATS_EN
  logic [31:0] stall_cnt_q;
  logic [31:0] flush_cnt_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (hazard && !ext_stall && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + 32'd1;
      if (flush_int && (flush_cnt_q != '1))            flush_cnt_q <= flush_cnt_q + 32'd1;
    end
  end

  assign stall_count = stall_cnt_q;
  assign flush_count = flush_cnt_q;
`else
  assign stall_count = '0;
  assign flush_count = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_unit.sv
// -----------------------------------------------------------------------------
// tb_pipe_hazard_unit
//
// Self-checking bench for pipe_hazard_unit (default parameters). A reference
// model keeps the in-flight instructions as a queue indexed by age since EX
// and derives forwarding, load-use and flag behaviour directly from that age.
// Directed steps cover the main scenarios; a randomized phase follows.
// -----------------------------------------------------------------------------
module tb_pipe_hazard_unit;

  localparam int REG_AW    = 5;
  localparam int FWD_DEPTH = 2;
  localparam int LOAD_LAT  = 1;
  localparam int ZERO_REG  = 31;
`ifdef PIPE_HAZARD_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              reset;
  logic              issue_valid, issue_we, issue_load;
  logic [REG_AW-1:0] issue_rd, issue_rn, issue_rm;
  logic              issue_rn_used, issue_rm_used, issue_set_flg, issue_use_flg;
  logic              br_taken, ext_stall;
  logic [2:0]        fwd_a, fwd_b;
  logic              fwd_flag, stall_pc, stall_ifid, bubble_idex, flush_ifid;
  logic [31:0]       stall_count, flush_count;

  int vectors    = 0;
  int miscompares = 0;

  pipe_hazard_unit #(
    .REG_AW(REG_AW), .FWD_DEPTH(FWD_DEPTH), .LOAD_LAT(LOAD_LAT), .ZERO_REG(ZERO_REG)
  ) dut (
    .clk(clk), .reset(reset),
    .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_we(issue_we),
    .issue_load(issue_load), .issue_rn(issue_rn), .issue_rm(issue_rm),
    .issue_rn_used(issue_rn_used), .issue_rm_used(issue_rm_used),
    .issue_set_flg(issue_set_flg), .issue_use_flg(issue_use_flg),
    .br_taken(br_taken), .ext_stall(ext_stall),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .fwd_flag(fwd_flag),
    .stall_pc(stall_pc), .stall_ifid(stall_ifid), .bubble_idex(bubble_idex),
    .flush_ifid(flush_ifid), .stall_count(stall_count), .flush_count(flush_count)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed running expected done");
    $fatal(1, "watchdog expired");
  end

  // ---------------------------------------------------------------------------
  // Reference model: queue position = number of unfrozen edges since the
  // instruction entered EX. A load result is not yet forwardable while its age
  // is below LOAD_LAT.
  // ---------------------------------------------------------------------------
  typedef struct packed {
    bit       valid;
    bit [4:0] rd;
    bit       we;
    bit       load;
    bit       setf;
  } instr_t;

  instr_t inflight[$];
  int     exp_stall = 0;
  int     exp_flush = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int find_src(input logic [4:0] src, input logic used, output bit pending);
    pending = 1'b0;
    if (!(issue_valid && used) || src == 5'(ZERO_REG)) return 0;
    foreach (inflight[k]) begin
      if (inflight[k].valid && inflight[k].we && inflight[k].rd == src) begin
        pending = inflight[k].load && (k < LOAD_LAT);
        return k + 1;
      end
    end
    return 0;
  endfunction

  function automatic void model_eval(output int ea, output int eb, output bit haz);
    bit pa, pb;
    ea  = find_src(issue_rn, issue_rn_used, pa);
    eb  = find_src(issue_rm, issue_rm_used, pb);
    haz = pa || pb;
  endfunction

  task automatic model_reset();
    inflight.delete();
    for (int i = 0; i < FWD_DEPTH; i++) inflight.push_back('0);
    exp_stall = 0;
    exp_flush = 0;
  endtask

  task automatic model_check();
    int ea, eb;
    bit haz, fl;
    model_eval(ea, eb, haz);
    fl = br_taken && issue_valid && !haz && !ext_stall;
    check("stall_pc",    32'(stall_pc),    32'(haz || ext_stall));
    check("stall_ifid",  32'(stall_ifid),  32'(haz || ext_stall));
    check("bubble_idex", 32'(bubble_idex), 32'(haz && !ext_stall));
    check("flush_ifid",  32'(flush_ifid),  32'(fl));
    check("fwd_flag",    32'(fwd_flag),
          32'(issue_use_flg && inflight[0].valid && inflight[0].setf));
    if (!haz) begin
      check("fwd_a", 32'(fwd_a), 32'(ea));
      check("fwd_b", 32'(fwd_b), 32'(eb));
    end
    check("stall_count", stall_count, STATS ? 32'(exp_stall) : 32'd0);
    check("flush_count", flush_count, STATS ? 32'(exp_flush) : 32'd0);
  endtask

  task automatic model_update();
    int ea, eb;
    bit haz;
    instr_t e;
    model_eval(ea, eb, haz);
    if (haz && !ext_stall) exp_stall++;
    if (br_taken && issue_valid && !haz && !ext_stall) exp_flush++;
    if (!ext_stall) begin
      e = '0;
      if (issue_valid && !haz)
        e = '{valid: 1'b1, rd: issue_rd, we: issue_we, load: issue_load, setf: issue_set_flg};
      inflight.push_front(e);
      if (inflight.size() > FWD_DEPTH) void'(inflight.pop_back());
    end
  endtask

  // Called at negedge + 1: check against the model, clock once, return at negedge.
  task automatic advance();
    model_check();
    model_update();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle();
    issue_valid = 0; issue_rd = '0; issue_we = 0; issue_load = 0;
    issue_rn = '0; issue_rm = '0; issue_rn_used = 0; issue_rm_used = 0;
    issue_set_flg = 0; issue_use_flg = 0; br_taken = 0; ext_stall = 0;
  endtask

  task automatic set_op(input bit v, input int rd, input bit we, input bit ld, input bit sf,
                        input int rn, input bit rnu, input int rm, input bit rmu,
                        input bit uf, input bit br);
    issue_valid = v; issue_rd = 5'(rd); issue_we = we; issue_load = ld; issue_set_flg = sf;
    issue_rn = 5'(rn); issue_rn_used = rnu; issue_rm = 5'(rm); issue_rm_used = rmu;
    issue_use_flg = uf; br_taken = br;
  endtask

  initial begin
    int r;
    idle();
    reset = 1'b0;
    model_reset();
    #1;
    check("rst_fwd_a", 32'(fwd_a), 32'd0);
    check("rst_fwd_b", 32'(fwd_b), 32'd0);
    check("rst_stall_pc", 32'(stall_pc), 32'd0);
    check("rst_bubble", 32'(bubble_idex), 32'd0);
    check("rst_counts", stall_count | flush_count, 32'd0);
    // Decode-side activity while in reset must not leak out.
    ext_stall = 1; br_taken = 1; issue_valid = 1;
    #1;
    check("rst_stall_quiet", 32'(stall_pc | stall_ifid), 32'd0);
    check("rst_flush_quiet", 32'(flush_ifid), 32'd0);
    idle();
    @(negedge clk);
    reset = 1'b1;
    #1;

    // ADD X1, then consumers reading it at increasing distance.
    set_op(1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0);                      #1 advance(); #1;
    set_op(1, 5, 1, 0, 0, 1, 1, 0, 0, 0, 0);                      #1;
    check("dir_fwd_a_ex", 32'(fwd_a), 32'd1);                     advance(); #1;
    set_op(1, 6, 1, 0, 0, 0, 0, 1, 1, 0, 0);                      #1;
    check("dir_fwd_b_mem", 32'(fwd_b), 32'd2);                    advance(); #1;
    set_op(1, 6, 1, 0, 0, 0, 0, 1, 1, 0, 0);                      #1;
    check("dir_fwd_b_gone", 32'(fwd_b), 32'd0);                   advance(); #1;

    // LDUR X2 then ADD X8, X2: exactly one stall cycle.
    set_op(1, 2, 1, 1, 0, 0, 0, 0, 0, 0, 0);                      advance(); #1;
    set_op(1, 8, 1, 0, 0, 2, 1, 0, 0, 0, 0);                      #1;
    check("dir_lu_stall", 32'({stall_pc, stall_ifid, bubble_idex}), 32'b111);
    advance(); #1;
    check("dir_lu_fwd_a", 32'(fwd_a), 32'd2);
    check("dir_lu_released", 32'({stall_pc, stall_ifid, bubble_idex}), 32'b000);
    check("dir_lu_count", stall_count, STATS ? 32'd1 : 32'd0);
    advance(); #1;

    // Zero register never forwards.
    set_op(1, 31, 1, 0, 0, 0, 0, 0, 0, 0, 0);                     advance(); #1;
    set_op(1, 9, 1, 0, 0, 31, 1, 31, 1, 0, 0);                    #1;
    check("dir_zero_fwd", 32'({fwd_a, fwd_b}), 32'd0);
    check("dir_zero_stall", 32'(stall_pc), 32'd0);                advance(); #1;

    // SUBS then taken B.cond.
    set_op(1, 7, 1, 0, 1, 0, 0, 0, 0, 0, 0);                      advance(); #1;
    set_op(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1);                      #1;
    check("dir_fwd_flag", 32'(fwd_flag), 32'd1);
    check("dir_flush", 32'(flush_ifid), 32'd1);                   advance(); #1;
    idle(); issue_use_flg = 1;                                    #1;
    check("dir_flush_once", 32'(flush_ifid), 32'd0);
    check("dir_flag_old", 32'(fwd_flag), 32'd0);
    check("dir_flush_count", flush_count, STATS ? 32'd1 : 32'd0); advance(); #1;

    // ext_stall for 3 cycles with LDUR X3 in EX.
    set_op(1, 3, 1, 1, 0, 0, 0, 0, 0, 0, 0);                      advance(); #1;
    set_op(1, 10, 1, 0, 0, 3, 1, 0, 0, 0, 1);
    ext_stall = 1;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("dir_ext_hold", 32'({stall_pc, stall_ifid, bubble_idex, flush_ifid}), 32'b1100);
      advance();
    end
    ext_stall = 0; br_taken = 0;                                  #1;
    check("dir_ext_resume", 32'(bubble_idex), 32'd1);             advance(); #1;
    check("dir_ext_fwd", 32'(fwd_a), 32'd2);
    check("dir_ext_count", stall_count, STATS ? 32'd2 : 32'd0);   advance(); #1;

    // Reset asserted between edges during a load-use stall.
    set_op(1, 4, 1, 1, 0, 0, 0, 0, 0, 0, 0);                      advance(); #1;
    set_op(1, 11, 1, 0, 0, 4, 1, 4, 1, 0, 0);                     #1;
    check("dir_pre_rst_stall", 32'(stall_pc), 32'd1);
    #2 reset = 1'b0;
    #1;
    check("dir_mid_rst_out",
          32'({fwd_a, fwd_b, fwd_flag, stall_pc, stall_ifid, bubble_idex, flush_ifid}), 32'd0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    model_reset();
    #1;
    check("dir_post_rst_fwd", 32'({fwd_a, fwd_b}), 32'd0);
    check("dir_post_rst_stall", 32'(stall_pc), 32'd0);
    advance(); #1;

    // Randomized phase: small register range so dependencies are frequent.
    for (int n = 0; n < 400; n++) begin
      r = int'($urandom_range(0, 4)); issue_rd = 5'((r == 4) ? ZERO_REG : r);
      r = int'($urandom_range(0, 4)); issue_rn = 5'((r == 4) ? ZERO_REG : r);
      r = int'($urandom_range(0, 4)); issue_rm = 5'((r == 4) ? ZERO_REG : r);
      issue_valid   = ($urandom_range(0, 7) != 0);
      issue_we      = ($urandom_range(0, 3) != 0);
      issue_load    = ($urandom_range(0, 2) == 0);
      issue_rn_used = ($urandom_range(0, 3) != 0);
      issue_rm_used = ($urandom_range(0, 1) != 0);
      issue_set_flg = ($urandom_range(0, 2) == 0);
      issue_use_flg = ($urandom_range(0, 2) == 0);
      br_taken      = ($urandom_range(0, 5) == 0);
      ext_stall     = ($urandom_range(0, 7) == 0);
      #1;
      advance();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_unit.md
Name: pipe_hazard_unit

Overview:
Parametrised hazard/forwarding controller for the in-order pipelined CPU. It generalises the fixed EX/MEM forwarding unit to any number of post-decode stages and any load latency. It keeps a shifting history of in-flight destination registers and drives four groups of outputs:
- forwarding-mux selects;
- load-use stalls with bubble insertion;
- condition-flag forwarding;
- IF/ID flush on a taken decode-stage branch.

Parameters:
REG_AW, 5, register address width
FWD_DEPTH, 2, number of in-flight stages tracked and forwardable (entry 0 = EX, entry 1 = MEM, ...); range 1..7
LOAD_LAT, 1, extra cycles after EX before load data is forwardable; must be < FWD_DEPTH
ZERO_REG, 31, register that never creates a dependency

Ports:
clk  in  1  clock, all state updates on rising edge
reset  in  1  asynchronous, active-low (0 clears all state immediately)
issue_valid  in  1  decode stage holds a real instruction
issue_rd  in  REG_AW  destination of decode instruction
issue_we  in  1  decode instruction writes issue_rd
issue_load  in  1  decode instruction is LDUR/LDURB
issue_rn, issue_rm  in  REG_AW  source registers
issue_rn_used, issue_rm_used  in  1  source actually read
issue_set_flg  in  1  decode instruction sets NZCV
issue_use_flg  in  1  decode instruction reads NZCV (B.cond)
br_taken  in  1  decode-stage branch resolved taken
ext_stall  in  1  global freeze (memory wait)
fwd_a, fwd_b  out  3  0 = regfile, k = forward from history entry k-1
fwd_flag  out  1  use combinational ALU flags instead of registered flags
stall_pc  out  1  hold PC
stall_ifid  out  1  hold IF/ID register
bubble_idex  out  1  load a NOP into ID/EX
flush_ifid  out  1  clear IF/ID to a NOP on the next edge
stall_count  out  32  load-use stall cycles (optional feature)
flush_count  out  32  flushes issued (optional feature)

Behaviour:
- History: FWD_DEPTH entries, each {valid, rd, we, cnt}, where cnt is the number of cycles until the result is forwardable.
- Per edge, unless ext_stall:
  - entry k <= entry k-1;
  - entry 0 <= issued instruction, or a bubble (valid=0) when hazard=1 or issue_valid=0;
  - cnt of every shifted entry decrements, saturating at 0.
- New entry cnt: LOAD_LAT if issue_load, else 0.
- Source match for entry k: issue_valid & src_used & valid & we & rd==src & src!=ZERO_REG. The youngest (lowest k) match wins; fwd = k+1. With no match, fwd=0.
- hazard: any winning match has cnt>0 (load-use). When hazard=1:
  - stall_pc=stall_ifid=bubble_idex=1;
  - fwd_a/fwd_b are still driven but don't-care.
- Flags: fwd_flag=1 when issue_use_flg and the entry-0 instruction set flags.
  - A flag setter in entry 1 or older has already registered, so fwd_flag=0.
  - The history stores one set_flg bit per entry.
- ext_stall=1:
  - history frozen;
  - stall_pc=stall_ifid=1, bubble_idex=0, flush_ifid=0;
  - counters hold.
- flush_ifid = br_taken & issue_valid & ~hazard & ~ext_stall, all combinational, zero latency. A branch suppressed by a hazard re-evaluates on the next cycle.
- Simultaneous hazard and br_taken: the stall wins and no flush occurs.
- All outputs are combinational from state and inputs. During reset, history valid=0, so fwd=0, all stalls 0 and flush 0.
- Reset asserted mid-stall: history clears at once and the stall deasserts without waiting for a clock edge.

Optional Feature:
PIPE_HAZARD_STATS_EN:
- Defined: stall_count increments on every cycle with hazard=1 & ~ext_stall, and flush_count increments on every cycle with flush_ifid=1. Both saturate at 32'hFFFFFFFF and reset to 0.
- Undefined: both ports are tied to 0 and no counter flops are built.

Test Plan:
- ADD X1 issued, next instruction reads rn=X1 → fwd_a=1. One cycle later, if the consumer instead reads rm=X1 → fwd_b=2; two cycles later → 0.
- LDUR X2 then ADD using X2 (LOAD_LAT=1):
  - first cycle: stall_pc=stall_ifid=bubble_idex=1 for exactly 1 cycle;
  - next cycle: fwd_a=2, stalls 0;
  - with the stats feature enabled: stall_count=1.
- Producer writes X31, consumer reads X31 → fwd_a=0, no stall.
- SUBS then B.cond taken in the next cycle → fwd_flag=1 and flush_ifid=1 for 1 cycle; flush_count=1.
- ext_stall held 3 cycles with LDUR in entry 0 → history frozen, bubble_idex=0, and the load-use stall resumes after release.
- reset driven to 0 mid-hazard, between clock edges → all outputs 0 immediately; after release the history is empty and fwd_a=fwd_b=0.
